// File: rtl/shift_result_buffer.sv
// Result FIFO behind the 4-bit right-shift stage: ready/valid capture, head presentation, zero flag, occupancy.
// Optional push statistics (stat_total, stat_zero) are built when SHIFT_RESULT_STATS_EN is defined.
module shift_result_buffer #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_zero,
   output logic [CNT_W-1:0] count
`ifdef SHIFT_RESULT_STATS_EN
   ,
   output logic [15:0]      stat_total,
   output logic [15:0]      stat_zero
`endif
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             push;
   logic             pop;

   // Ready and valid come only from the registered count, so a stalled
   // consumer never creates a combinational path back to the shift stage.
   assign in_ready  = (count != FULL);
   assign out_valid = (count != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   // Head is forced to zero while empty so reset/clear present a clean 0.
   assign out_data  = out_valid ? mem[rd_ptr] : '0;
   assign out_zero  = out_valid && (out_data == '0);

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push && !pop) begin
            count <= count + 1'b1;
         end else if (pop && !push) begin
            count <= count - 1'b1;
         end
      end
   end

   // Storage is not reset; entries become visible only through count.
   always_ff @(posedge clk) begin
      if (!rst && !clear && push) begin
         mem[wr_ptr] <= in_data;
      end
   end

`ifdef SHIFT_RESULT_STATS_EN
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         stat_total <= '0;
         stat_zero  <= '0;
      end else if (push) begin
         if (stat_total != 16'hFFFF) begin
            stat_total <= stat_total + 16'd1;
         end
         if ((in_data == '0) && (stat_zero != 16'hFFFF)) begin
            stat_zero <= stat_zero + 16'd1;
         end
      end
   end
`endif

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (count <= FULL);
      end
   end
`endif

endmodule

// File: tb/tb_shift_result_buffer.sv
// Directed bench for shift_result_buffer: queue model compared every cycle plus literal checkpoints.
module tb_shift_result_buffer;
   localparam int WIDTH = 4;
   localparam int DEPTH = 4;
   localparam int CNT_W = 3;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             clear = 1'b0;
   logic [WIDTH-1:0] in_data = '0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic             out_zero;
   logic [CNT_W-1:0] count;
`ifdef SHIFT_RESULT_STATS_EN
   logic [15:0]      stat_total;
   logic [15:0]      stat_zero;
`endif

   shift_result_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk),
      .rst(rst),
      .clear(clear),
      .in_data(in_data),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .out_data(out_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_zero(out_zero),
      .count(count)
`ifdef SHIFT_RESULT_STATS_EN
      ,
      .stat_total(stat_total),
      .stat_zero(stat_zero)
`endif
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   logic [WIDTH-1:0] mq[$];
   int m_total = 0;
   int m_zero = 0;

   task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic compare();
      chk("count", 32'(count), 32'(mq.size()));
      chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
      chk("in_ready", 32'(in_ready), 32'(mq.size() != DEPTH));
      chk("out_zero", 32'(out_zero), 32'((mq.size() != 0) && (mq[0] == 0)));
      if (mq.size() != 0) chk("out_data", 32'(out_data), 32'(mq[0]));
`ifdef SHIFT_RESULT_STATS_EN
      chk("stat_total", 32'(stat_total), 32'(m_total));
      chk("stat_zero", 32'(stat_zero), 32'(m_zero));
`endif
   endtask

   // Advance the model by the rules for this cycle's inputs, clock, then compare.
   task automatic step();
      bit do_push;
      bit do_pop;
      if (rst || clear) begin
         mq.delete();
         m_total = 0;
         m_zero = 0;
      end else begin
         do_push = in_valid && (mq.size() < DEPTH);
         do_pop  = out_ready && (mq.size() > 0);
         if (do_pop) void'(mq.pop_front());
         if (do_push) begin
            mq.push_back(in_data);
            if (m_total < 65535) m_total++;
            if (in_data == 0 && m_zero < 65535) m_zero++;
         end
      end
      @(posedge clk);
      #1;
      compare();
   endtask

   task automatic push_one(input logic [WIDTH-1:0] d);
      in_valid = 1'b1;
      in_data = d;
      step();
      in_valid = 1'b0;
   endtask

   logic [WIDTH-1:0] exp_fill[4];
   logic [WIDTH-1:0] exp_wrap[6];

   initial begin
      exp_fill = '{4'h8, 4'h4, 4'h2, 4'h1};
      exp_wrap = '{4'hA, 4'hB, 4'hC, 4'hD, 4'h1, 4'h2};

      // reset then idle
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      chk("rst_count", 32'(count), 0);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_in_ready", 32'(in_ready), 1);
      chk("rst_out_zero", 32'(out_zero), 0);
      chk("rst_out_data", 32'(out_data), 0);
      step();

      // single result, latency 1
      push_one(4'b0011);
      chk("single_data", 32'(out_data), 32'h3);
      chk("single_valid", 32'(out_valid), 1);
      chk("single_count", 32'(count), 1);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("single_drained", 32'(out_valid), 0);
      chk("single_count0", 32'(count), 0);

      // fill, overflow attempt, ordered drain
      for (int i = 0; i < 4; i++) push_one(exp_fill[i]);
      chk("full_count", 32'(count), 4);
      chk("full_in_ready", 32'(in_ready), 0);
      push_one(4'hF);
      chk("full_ignored", 32'(count), 4);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("drain_order", 32'(out_data), 32'(exp_fill[i]));
         step();
      end
      out_ready = 1'b0;
      chk("drain_empty", 32'(out_valid), 0);

      // simultaneous push/pop at full across pointer wrap
      push_one(4'hA);
      push_one(4'hB);
      push_one(4'hC);
      push_one(4'hD);
      for (int i = 0; i < 6; i++) begin
         in_valid = 1'b1;
         in_data = 4'(i);
         out_ready = 1'b1;
         chk("wrap_head", 32'(out_data), 32'(exp_wrap[i]));
         step();
      end
      in_valid = 1'b0;
      chk("wrap_count", 32'(count), 3);
      chk("wrap_next", 32'(out_data), 32'h3);
      step();
      step();
      step();
      out_ready = 1'b0;
      chk("wrap_empty", 32'(out_valid), 0);

      // zero flag
      push_one(4'h0);
      push_one(4'h1);
      chk("zero_flag_set", 32'(out_zero), 1);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("zero_flag_clr", 32'(out_zero), 0);
      chk("zero_next_data", 32'(out_data), 32'h1);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;

      // clear with a concurrent push
      push_one(4'h5);
      push_one(4'h6);
      push_one(4'h7);
      chk("pre_clear_count", 32'(count), 3);
      clear = 1'b1;
      in_valid = 1'b1;
      in_data = 4'h9;
      step();
      clear = 1'b0;
      in_valid = 1'b0;
      chk("clear_count", 32'(count), 0);
      chk("clear_valid", 32'(out_valid), 0);
`ifdef SHIFT_RESULT_STATS_EN
      chk("clear_stat_total", 32'(stat_total), 0);
      chk("clear_stat_zero", 32'(stat_zero), 0);
`endif
      step();

      // reset mid-stream with a concurrent push
      push_one(4'h0);
      push_one(4'h6);
      push_one(4'h7);
      rst = 1'b1;
      in_valid = 1'b1;
      in_data = 4'h9;
      step();
      rst = 1'b0;
      in_valid = 1'b0;
      chk("rst_mid_count", 32'(count), 0);
      chk("rst_mid_valid", 32'(out_valid), 0);
      chk("rst_mid_in_ready", 32'(in_ready), 1);
`ifdef SHIFT_RESULT_STATS_EN
      chk("rst_stat_total", 32'(stat_total), 0);
      chk("rst_stat_zero", 32'(stat_zero), 0);
`endif
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/shift_result_buffer.md
Name: shift_result_buffer

Overview:
- Downstream stage of the 4-bit right-shift unit. Captures each shifted result (A_SR) with a valid/ready handshake and buffers it in a small FIFO.
- Presents results one at a time to the ALU result consumer (output register / display logic), with a zero flag and an occupancy count.
- Decouples the combinational shift path from a consumer that may stall.

Parameters:
- WIDTH, 4, data width; matches the shift stage's A_SR width.
- DEPTH, 4, number of FIFO entries; power of two, ≥2.
- CNT_W, 3, width of occupancy count; equals log2(DEPTH)+1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- clear  input  1  synchronous flush of buffer contents.
- in_data  input  WIDTH  shifted result from the shift stage (A_SR).
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  buffer can accept in_data this cycle.
- out_data  output  WIDTH  head-of-FIFO result.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer accepts out_data this cycle.
- out_zero  output  1  head entry equals 0; qualified by out_valid.
- count  output  CNT_W  number of stored entries, 0..DEPTH.

Behaviour:
- Clock and reset: one clock. rst is synchronous and active-high.
- Reset values: after a reset cycle, the buffer is empty:
  - count = 0, out_valid = 0, in_ready = 1, out_zero = 0, out_data = 0.
  - Read/write pointers = 0.
- Storage: circular buffer of DEPTH entries. Write pointer and read pointer are each log2(DEPTH) bits and wrap from DEPTH-1 to 0.
- Handshake definitions:
  - push = in_valid && in_ready.
  - pop = out_valid && out_ready.
  - in_valid and in_data may change freely while in_ready = 0; nothing is captured.
- Ready/valid outputs:
  - in_ready = (count != DEPTH). It is registered-state derived and does not depend combinationally on out_ready (no full-passthrough).
  - out_valid = (count != 0).
  - out_data = mem[rd_ptr] while valid; it holds its value while out_valid && !out_ready.
- Latency: a value pushed into an empty buffer appears on out_data/out_valid in the next cycle. There is no same-cycle bypass.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged, both pointers advance.
  - neither: hold.
- Full: when count = DEPTH, in_ready = 0. A pop in that cycle frees a slot, so in_ready = 1 in the next cycle.
- Empty: when count = 0, out_valid = 0 and out_ready is ignored. No pointer movement and no underflow.
- out_zero = out_valid && (out_data == 0).
- Priority: rst > clear > push/pop. clear empties the buffer in one cycle:
  - Pointers and count go to 0.
  - Storage contents are not cleared.
  - A push or pop in the same cycle is discarded.
- Reset mid-operation: all stored entries are lost, outputs take their reset values next cycle, and handshakes in the reset cycle are discarded.
- Invariant (checked by assertion): count never exceeds DEPTH and never goes negative.

Optional Feature:
- Macro: SHIFT_RESULT_STATS_EN.
- When defined, two extra outputs are added:
  - stat_total (16 bits): saturating count of pushes.
  - stat_zero (16 bits): saturating count of pushes with in_data == 0.
- Both counters reset to 0 on rst and on clear, and saturate at 16'hFFFF.
- When not defined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset then idle: assert rst for 2 cycles → count = 0, out_valid = 0, in_ready = 1, out_zero = 0.
- Single result, latency 1: push 4'b0011 with out_ready = 0 → next cycle out_valid = 1, out_data = 4'b0011, count = 1. Raise out_ready → following cycle out_valid = 0, count = 0.
- Fill and order (DEPTH = 4): push 4'h8, 4'h4, 4'h2, 4'h1 with out_ready = 0 → count = 4, in_ready = 0. A fifth push of 4'hF is ignored. Drain → outputs 8, 4, 2, 1 in order, then out_valid = 0.
- Simultaneous push/pop at full and pointer wrap: hold full, assert in_valid = 1 and out_ready = 1 for 6 cycles with data 0..5:
  - Cycle 1: only pop occurs (in_ready = 0).
  - Thereafter: one push and one pop per cycle.
  - Expected: count stays at 3-4, FIFO order is preserved across the pointer wrap, and no value is duplicated or lost.
- Zero flag: push 4'b0000 then 4'b0001 → out_zero = 1 while the head is 0, then out_zero = 0 after the pop.
- Clear vs reset:
  - With 3 entries stored, assert clear together with in_valid = 1 → next cycle count = 0, out_valid = 0, and the pushed value is discarded.
  - Repeat using rst mid-stream → same result.
  - With SHIFT_RESULT_STATS_EN defined: stat_total and stat_zero read 0 after both clear and rst.
